// File: rtl/operand_station.sv
// Operand buffer: holds up to ENTRY_COUNT operand pairs, snoops result buses for pending operands, issues READY pairs.
// Define OPERAND_STATION_AGE_ORDER_EN to issue the oldest READY entry instead of the lowest-index one.
module operand_station #(
    parameter int SIZE          = 32,
    parameter int STATION_COUNT = 2,
    parameter int BUS_COUNT     = 1,
    parameter int ENTRY_COUNT   = 4,
    localparam int STATION_INDEX_SIZE = (STATION_COUNT > 1) ? $clog2(STATION_COUNT) : 1,
    localparam int ENTRY_INDEX_SIZE   = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1,
    localparam int OCC_SIZE           = $clog2(ENTRY_COUNT + 1)
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic [BUS_COUNT-1:0]                           bus_asserted,
    input  logic [BUS_COUNT-1:0][STATION_INDEX_SIZE-1:0]   bus_source,
    input  logic [BUS_COUNT-1:0][SIZE-1:0]                 bus_value,
    input  logic                                           alloc_valid,
    output logic                                           alloc_ready,
    input  logic                                           alloc_a_pending,
    input  logic                                           alloc_b_pending,
    input  logic [STATION_INDEX_SIZE-1:0]                  alloc_a_tag,
    input  logic [STATION_INDEX_SIZE-1:0]                  alloc_b_tag,
    input  logic [SIZE-1:0]                                alloc_a_value,
    input  logic [SIZE-1:0]                                alloc_b_value,
    output logic                                           issue_valid,
    input  logic                                           issue_ready,
    output logic [SIZE-1:0]                                issue_a,
    output logic [SIZE-1:0]                                issue_b,
    output logic [ENTRY_INDEX_SIZE-1:0]                    issue_entry,
    output logic [OCC_SIZE-1:0]                            occupancy
);

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_WAITING = 2'd1,
        ST_READY   = 2'd2
    } entry_state_e;

    entry_state_e                  state_q  [ENTRY_COUNT];
    entry_state_e                  state_d  [ENTRY_COUNT];
    logic [SIZE-1:0]               a_q      [ENTRY_COUNT];
    logic [SIZE-1:0]               a_d      [ENTRY_COUNT];
    logic [SIZE-1:0]               b_q      [ENTRY_COUNT];
    logic [SIZE-1:0]               b_d      [ENTRY_COUNT];
    logic [STATION_INDEX_SIZE-1:0] a_tag_q  [ENTRY_COUNT];
    logic [STATION_INDEX_SIZE-1:0] a_tag_d  [ENTRY_COUNT];
    logic [STATION_INDEX_SIZE-1:0] b_tag_q  [ENTRY_COUNT];
    logic [STATION_INDEX_SIZE-1:0] b_tag_d  [ENTRY_COUNT];
    logic [ENTRY_COUNT-1:0]        a_pend_q, a_pend_d, b_pend_q, b_pend_d;

    logic [ENTRY_INDEX_SIZE-1:0]   alloc_idx, sel_idx;
    logic                          sel_found, alloc_fire, issue_fire;
    logic [SIZE:0]                 alloc_a_snoop, alloc_b_snoop, snoop_a, snoop_b;

    // Returns {hit, value}; scanning from the top down lets the lowest-index bus win.
    function automatic logic [SIZE:0] snoop(
        input logic [STATION_INDEX_SIZE-1:0]                tag,
        input logic [BUS_COUNT-1:0]                         asserted,
        input logic [BUS_COUNT-1:0][STATION_INDEX_SIZE-1:0] source,
        input logic [BUS_COUNT-1:0][SIZE-1:0]               value
    );
        logic [SIZE:0] r;
        r = '0;
        for (int j = BUS_COUNT - 1; j >= 0; j--) begin
            if (asserted[j] && source[j] == tag) r = {1'b1, value[j]};
        end
        return r;
    endfunction

    assign alloc_a_snoop = snoop(alloc_a_tag, bus_asserted, bus_source, bus_value);
    assign alloc_b_snoop = snoop(alloc_b_tag, bus_asserted, bus_source, bus_value);
    assign alloc_fire    = alloc_valid && alloc_ready;
    assign issue_fire    = issue_valid && issue_ready;

`ifdef OPERAND_STATION_AGE_ORDER_EN
    // age is the entry's rank among occupied entries: 0 is oldest, ranks stay dense so they never wrap.
    logic [ENTRY_INDEX_SIZE-1:0] age_q [ENTRY_COUNT];
    logic [ENTRY_INDEX_SIZE-1:0] age_d [ENTRY_COUNT];
    logic [ENTRY_INDEX_SIZE-1:0] best_age;

    always_comb begin
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            age_d[i] = age_q[i];
            if (issue_fire && state_q[i] != ST_FREE && age_q[i] > age_q[issue_entry])
                age_d[i] = age_q[i] - 1'b1;
        end
        if (alloc_fire)
            age_d[alloc_idx] = ENTRY_INDEX_SIZE'(occupancy - OCC_SIZE'(issue_fire));
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < ENTRY_COUNT; i++) age_q[i] <= reset ? '0 : age_d[i];
    end
`endif

    always_comb begin
        alloc_ready = 1'b0;
        alloc_idx   = '0;
        occupancy   = '0;
        sel_found   = 1'b0;
        sel_idx     = '0;
        for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
            if (state_q[i] == ST_FREE) begin
                alloc_ready = 1'b1;
                alloc_idx   = ENTRY_INDEX_SIZE'(i);
            end else begin
                occupancy = occupancy + OCC_SIZE'(1);
            end
        end
`ifdef OPERAND_STATION_AGE_ORDER_EN
        best_age = '0;
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            if (state_q[i] == ST_READY && (!sel_found || age_q[i] < best_age)) begin
                sel_found = 1'b1;
                sel_idx   = ENTRY_INDEX_SIZE'(i);
                best_age  = age_q[i];
            end
        end
`else
        for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
            if (state_q[i] == ST_READY) begin
                sel_found = 1'b1;
                sel_idx   = ENTRY_INDEX_SIZE'(i);
            end
        end
`endif
        issue_valid = sel_found;
        issue_entry = sel_found ? sel_idx : '0;
        issue_a     = sel_found ? a_q[sel_idx] : '0;
        issue_b     = sel_found ? b_q[sel_idx] : '0;
    end

    always_comb begin
        snoop_a  = '0;
        snoop_b  = '0;
        a_pend_d = a_pend_q;
        b_pend_d = b_pend_q;
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            state_d[i] = state_q[i];
            a_d[i]     = a_q[i];
            b_d[i]     = b_q[i];
            a_tag_d[i] = a_tag_q[i];
            b_tag_d[i] = b_tag_q[i];
            if (state_q[i] == ST_WAITING) begin
                snoop_a = snoop(a_tag_q[i], bus_asserted, bus_source, bus_value);
                snoop_b = snoop(b_tag_q[i], bus_asserted, bus_source, bus_value);
                if (a_pend_q[i] && snoop_a[SIZE]) begin
                    a_pend_d[i] = 1'b0;
                    a_d[i]      = snoop_a[SIZE-1:0];
                end
                if (b_pend_q[i] && snoop_b[SIZE]) begin
                    b_pend_d[i] = 1'b0;
                    b_d[i]      = snoop_b[SIZE-1:0];
                end
                if (!a_pend_d[i] && !b_pend_d[i]) state_d[i] = ST_READY;
            end
            if (issue_fire && issue_entry == ENTRY_INDEX_SIZE'(i)) state_d[i] = ST_FREE;
            if (alloc_fire && alloc_idx == ENTRY_INDEX_SIZE'(i)) begin
                a_pend_d[i] = alloc_a_pending && !alloc_a_snoop[SIZE];
                b_pend_d[i] = alloc_b_pending && !alloc_b_snoop[SIZE];
                a_tag_d[i]  = alloc_a_tag;
                b_tag_d[i]  = alloc_b_tag;
                a_d[i]      = !alloc_a_pending ? alloc_a_value
                            : (alloc_a_snoop[SIZE] ? alloc_a_snoop[SIZE-1:0] : '0);
                b_d[i]      = !alloc_b_pending ? alloc_b_value
                            : (alloc_b_snoop[SIZE] ? alloc_b_snoop[SIZE-1:0] : '0);
                state_d[i]  = (a_pend_d[i] || b_pend_d[i]) ? ST_WAITING : ST_READY;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_pend_q <= '0;
            b_pend_q <= '0;
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                state_q[i] <= ST_FREE;
                a_q[i]     <= '0;
                b_q[i]     <= '0;
                a_tag_q[i] <= '0;
                b_tag_q[i] <= '0;
            end
        end else begin
            a_pend_q <= a_pend_d;
            b_pend_q <= b_pend_d;
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                state_q[i] <= state_d[i];
                a_q[i]     <= a_d[i];
                b_q[i]     <= b_d[i];
                a_tag_q[i] <= a_tag_d[i];
                b_tag_q[i] <= b_tag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_operand_station.sv
// Self-checking bench for operand_station: directed scenarios plus random traffic against an entry-list model.
module tb_operand_station;
    localparam int SIZE = 32;
    localparam int SC   = 4;
    localparam int BC   = 2;
    localparam int EC   = 4;
    localparam int SIW  = 2;
    localparam int EIW  = 2;
    localparam int OW   = 3;
`ifdef OPERAND_STATION_AGE_ORDER_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    logic                         clock, reset;
    logic [BC-1:0]                bus_asserted;
    logic [BC-1:0][SIW-1:0]       bus_source;
    logic [BC-1:0][SIZE-1:0]      bus_value;
    logic                         alloc_valid, alloc_ready;
    logic                         alloc_a_pending, alloc_b_pending;
    logic [SIW-1:0]               alloc_a_tag, alloc_b_tag;
    logic [SIZE-1:0]              alloc_a_value, alloc_b_value;
    logic                         issue_valid, issue_ready;
    logic [SIZE-1:0]              issue_a, issue_b;
    logic [EIW-1:0]               issue_entry;
    logic [OW-1:0]                occupancy;

    operand_station #(.SIZE(SIZE), .STATION_COUNT(SC), .BUS_COUNT(BC), .ENTRY_COUNT(EC)) dut (
        .clock(clock), .reset(reset),
        .bus_asserted(bus_asserted), .bus_source(bus_source), .bus_value(bus_value),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_a_pending(alloc_a_pending), .alloc_b_pending(alloc_b_pending),
        .alloc_a_tag(alloc_a_tag), .alloc_b_tag(alloc_b_tag),
        .alloc_a_value(alloc_a_value), .alloc_b_value(alloc_b_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_a(issue_a), .issue_b(issue_b), .issue_entry(issue_entry),
        .occupancy(occupancy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_err = 0;
    int n_checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: per-entry status (0 free, 1 waiting, 2 ready) plus an allocation sequence number for age.
    int          m_st  [EC];
    logic [31:0] m_a   [EC];
    logic [31:0] m_b   [EC];
    bit          m_ap  [EC];
    bit          m_bp  [EC];
    int          m_at  [EC];
    int          m_bt  [EC];
    longint      m_seq [EC];
    longint      seq_ctr = 0;
    bit          live = 0;

    function automatic int m_sel();
        int s = -1;
        for (int i = 0; i < EC; i++) begin
            if (m_st[i] == 2) begin
                if (s < 0) s = i;
                else if (AGE && m_seq[i] < m_seq[s]) s = i;
            end
        end
        return s;
    endfunction

    function automatic bit bus_find(input int tag, output logic [31:0] v);
        v = '0;
        for (int j = 0; j < BC; j++) begin
            if (bus_asserted[j] && int'(bus_source[j]) == tag) begin
                v = bus_value[j];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    always @(posedge clock) begin
        int s, f;
        logic [31:0] v;
        if (reset) begin
            live = 1'b1;
            for (int i = 0; i < EC; i++) begin
                m_st[i] = 0; m_a[i] = '0; m_b[i] = '0; m_ap[i] = 0; m_bp[i] = 0;
                m_at[i] = 0; m_bt[i] = 0; m_seq[i] = 0;
            end
        end else if (live) begin
            s = m_sel();
            f = -1;
            for (int i = EC - 1; i >= 0; i--) if (m_st[i] == 0) f = i;
            for (int i = 0; i < EC; i++) begin
                if (m_st[i] == 1) begin
                    if (m_ap[i] && bus_find(m_at[i], v)) begin m_a[i] = v; m_ap[i] = 0; end
                    if (m_bp[i] && bus_find(m_bt[i], v)) begin m_b[i] = v; m_bp[i] = 0; end
                    if (!m_ap[i] && !m_bp[i]) m_st[i] = 2;
                end
            end
            if (s >= 0 && issue_ready) m_st[s] = 0;
            if (alloc_valid && f >= 0) begin
                m_at[f] = int'(alloc_a_tag);
                m_bt[f] = int'(alloc_b_tag);
                m_ap[f] = 0; m_bp[f] = 0;
                m_a[f]  = alloc_a_value;
                m_b[f]  = alloc_b_value;
                if (alloc_a_pending) begin
                    if (!bus_find(m_at[f], m_a[f])) m_ap[f] = 1;
                end
                if (alloc_b_pending) begin
                    if (!bus_find(m_bt[f], m_b[f])) m_bp[f] = 1;
                end
                m_st[f]  = (m_ap[f] || m_bp[f]) ? 1 : 2;
                m_seq[f] = seq_ctr;
                seq_ctr++;
            end
        end
    end

    always @(negedge clock) begin
        int s, occ;
        bit any_free;
        if (live) begin
            s = m_sel();
            occ = 0;
            any_free = 0;
            for (int i = 0; i < EC; i++) begin
                if (m_st[i] == 0) any_free = 1;
                else occ++;
            end
            chk("alloc_ready", 64'(alloc_ready), 64'(any_free));
            chk("occupancy", 64'(occupancy), 64'(occ));
            chk("issue_valid", 64'(issue_valid), 64'(s >= 0));
            chk("issue_entry", 64'(issue_entry), (s >= 0) ? 64'(s) : 64'd0);
            chk("issue_a", 64'(issue_a), (s >= 0) ? 64'(m_a[s]) : 64'd0);
            chk("issue_b", 64'(issue_b), (s >= 0) ? 64'(m_b[s]) : 64'd0);
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus_asserted = '0; bus_source = '0; bus_value = '0;
        alloc_valid = 0; alloc_a_pending = 0; alloc_b_pending = 0;
        alloc_a_tag = '0; alloc_b_tag = '0; alloc_a_value = '0; alloc_b_value = '0;
        issue_ready = 0;
    endtask

    task automatic do_alloc(input bit ap, input int at, input logic [31:0] av,
                            input bit bp, input int bt, input logic [31:0] bv);
        alloc_valid = 1; alloc_a_pending = ap; alloc_b_pending = bp;
        alloc_a_tag = SIW'(at); alloc_b_tag = SIW'(bt);
        alloc_a_value = av; alloc_b_value = bv;
    endtask

    task automatic set_bus(input int j, input bit as, input int src, input logic [31:0] v);
        bus_asserted[j] = as; bus_source[j] = SIW'(src); bus_value[j] = v;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        tick();
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_issue_entry", 64'(issue_entry), 64'd0);

        // a=5 ready, b waits on tag 1
        do_alloc(0, 0, 32'd5, 1, 1, 32'd0);
        tick();
        alloc_valid = 0;
        chk("bwait_issue_valid", 64'(issue_valid), 64'd0);
        set_bus(0, 1, 1, 32'h2A);
        tick();
        set_bus(0, 0, 0, 0);
        chk("cap_issue_valid", 64'(issue_valid), 64'd1);
        chk("cap_issue_a", 64'(issue_a), 64'd5);
        chk("cap_issue_b", 64'(issue_b), 64'h2A);
        issue_ready = 1;
        tick();
        issue_ready = 0;
        chk("cap_drained_occ", 64'(occupancy), 64'd0);

        // allocation-cycle bypass
        do_alloc(1, 0, 32'd0, 0, 0, 32'd9);
        set_bus(0, 1, 0, 32'd7);
        tick();
        alloc_valid = 0;
        set_bus(0, 0, 0, 0);
        chk("byp_issue_valid", 64'(issue_valid), 64'd1);
        chk("byp_issue_a", 64'(issue_a), 64'd7);
        chk("byp_issue_b", 64'(issue_b), 64'd9);
        issue_ready = 1;
        tick();
        issue_ready = 0;

        // fill, then release one at a time
        for (int k = 0; k < EC; k++) begin
            do_alloc(1, 3, 0, 1, 3, 0);
            tick();
        end
        alloc_valid = 0;
        chk("full_alloc_ready", 64'(alloc_ready), 64'd0);
        chk("full_occupancy", 64'(occupancy), 64'd4);
        chk("full_issue_valid", 64'(issue_valid), 64'd0);
        set_bus(1, 1, 3, 32'h11);
        tick();
        set_bus(1, 0, 0, 0);
        chk("full_ready_valid", 64'(issue_valid), 64'd1);
        issue_ready = 1;
        do_alloc(0, 0, 32'hA, 0, 0, 32'hB);
        tick();
        chk("rel1_occupancy", 64'(occupancy), 64'd3);
        chk("rel1_alloc_ready", 64'(alloc_ready), 64'd1);
        tick();
        alloc_valid = 0;
        chk("rel2_occupancy", 64'(occupancy), 64'd3);
        repeat (6) tick();
        issue_ready = 0;
        chk("rel_drained_occ", 64'(occupancy), 64'd0);

        // entry 2 allocated before entry 0; both READY
        do_alloc(0, 0, 32'd1, 0, 0, 32'd2);
        tick();
        do_alloc(1, 3, 0, 0, 0, 32'd3);
        tick();
        do_alloc(1, 2, 0, 0, 0, 32'd4);
        tick();
        alloc_valid = 0;
        issue_ready = 1;
        tick();
        issue_ready = 0;
        set_bus(1, 1, 2, 32'h33);
        tick();
        set_bus(1, 0, 0, 0);
        do_alloc(0, 0, 32'h44, 0, 0, 32'h55);
        tick();
        alloc_valid = 0;
        chk("age_issue_valid", 64'(issue_valid), 64'd1);
        chk("age_issue_entry", 64'(issue_entry), AGE ? 64'd2 : 64'd0);
        chk("age_issue_a", 64'(issue_a), AGE ? 64'h33 : 64'h44);
        set_bus(0, 1, 3, 32'h66);
        issue_ready = 1;
        tick();
        set_bus(0, 0, 0, 0);
        repeat (4) tick();
        issue_ready = 0;
        chk("age_drained_occ", 64'(occupancy), 64'd0);

        // reset beats a concurrent bus match
        for (int k = 0; k < 3; k++) begin
            do_alloc(1, 1, 0, 1, 1, 0);
            tick();
        end
        alloc_valid = 0;
        chk("pre_rst_occ", 64'(occupancy), 64'd3);
        reset = 1;
        set_bus(0, 1, 1, 32'h77);
        tick();
        reset = 0;
        chk("mid_rst_occ", 64'(occupancy), 64'd0);
        chk("mid_rst_valid", 64'(issue_valid), 64'd0);
        chk("mid_rst_ready", 64'(alloc_ready), 64'd1);
        tick();
        set_bus(0, 0, 0, 0);
        chk("post_rst_valid", 64'(issue_valid), 64'd0);
        chk("post_rst_occ", 64'(occupancy), 64'd0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            alloc_valid     = ($urandom_range(0, 99) < 60);
            alloc_a_pending = $urandom_range(0, 1);
            alloc_b_pending = $urandom_range(0, 1);
            alloc_a_tag     = SIW'($urandom_range(0, SC - 1));
            alloc_b_tag     = SIW'($urandom_range(0, SC - 1));
            alloc_a_value   = $urandom;
            alloc_b_value   = $urandom;
            for (int j = 0; j < BC; j++)
                set_bus(j, $urandom_range(0, 1), $urandom_range(0, SC - 1), $urandom);
            issue_ready     = ($urandom_range(0, 99) < 50);
            reset           = ($urandom_range(0, 199) == 0);
            tick();
        end
        idle_inputs();
        reset = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/operand_station.md
OPERAND_STATION -- requirements
Module: operand_station

Interface
REQ-001 SHALL have parameter SIZE, default 32: operand and bus value width in bits.
REQ-002 SHALL have parameter STATION_COUNT, default 2: number of producing stations; STATION_INDEX_SIZE = $clog2(STATION_COUNT) is the tag width.
REQ-003 SHALL have parameter BUS_COUNT, default 1: number of result buses snooped.
REQ-004 SHALL have parameter ENTRY_COUNT, default 4: number of buffered entries; ENTRY_INDEX_SIZE = $clog2(ENTRY_COUNT).
REQ-005 SHALL have the following ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- bus_asserted[BUS_COUNT]  input  1 each  bus j carries a valid result this cycle.
- bus_source[BUS_COUNT]  input  STATION_INDEX_SIZE each  tag of the producing station.
- bus_value[BUS_COUNT]  input  SIZE each  result value.
- alloc_valid  input  1  allocation request.
- alloc_ready  output  1  a free entry exists.
- alloc_a_pending / alloc_b_pending  input  1  operand awaits a bus result.
- alloc_a_tag / alloc_b_tag  input  STATION_INDEX_SIZE  producer tag when pending.
- alloc_a_value / alloc_b_value  input  SIZE  operand value when not pending.
- issue_valid  output  1  a selected entry has both operands.
- issue_ready  input  1  downstream accepts the issue.
- issue_a / issue_b  output  SIZE  operands of the selected entry.
- issue_entry  output  ENTRY_INDEX_SIZE  index of the selected entry.
- occupancy  output  $clog2(ENTRY_COUNT+1)  count of non-FREE entries.

Function
REQ-006 Each entry SHALL be in one of three states: FREE, WAITING (at least one operand pending), READY (both operands captured).
REQ-007 An allocation SHALL fire on alloc_valid && alloc_ready and SHALL write the lowest-index FREE entry.
REQ-008 A fired allocation SHALL place the entry in READY when neither operand is pending after bypass (REQ-011), otherwise in WAITING.
REQ-009 A WAITING entry SHALL capture a pending operand when bus_asserted[j] && bus_source[j] == tag for some j; the lowest matching j SHALL win.
REQ-010 Both operands of one entry SHALL be capturable in the same cycle, from the same bus or from different buses; the entry SHALL become READY on the next edge.
REQ-011 Allocation-cycle bypass: a pending operand whose tag matches a bus asserted in the allocation cycle SHALL be captured at allocation.
REQ-012 issue_valid SHALL be high iff at least one entry is READY; the selection rule is defined in REQ-020/021; issue outputs SHALL be combinational from registered entry state.
REQ-013 On issue_valid && issue_ready, the selected entry SHALL become FREE on the next edge.
REQ-014 alloc_ready SHALL be derived from registered state only; an entry freed by issue SHALL become allocatable on the following cycle.
REQ-015 Allocation and issue in the same cycle SHALL both take effect, and occupancy SHALL remain unchanged.
REQ-016 When issue_valid is 0, issue_a, issue_b and issue_entry SHALL be 0.
REQ-017 Bus results whose tag matches no pending operand SHALL be ignored; FREE and READY entries SHALL never capture.

Reset
REQ-018 While reset is high at a clock edge, all entries SHALL become FREE and stored operands and tags SHALL be zeroed; reset SHALL override a concurrent allocation, capture or issue.
REQ-019 After reset: alloc_ready=1, issue_valid=0, issue_a=0, issue_b=0, issue_entry=0, occupancy=0.

Configuration
REQ-020 With macro OPERAND_STATION_AGE_ORDER_EN defined, each entry SHALL record an age at allocation, and issue SHALL select the oldest READY entry; ages SHALL be maintained so that ordering is correct across arbitrarily long runs without wrap-around error.
REQ-021 Without OPERAND_STATION_AGE_ORDER_EN, issue SHALL select the lowest-index READY entry, and no age storage SHALL exist.

Verification
REQ-022 Reset, then idle -> alloc_ready=1, issue_valid=0, occupancy=0.
REQ-023 Allocate a=5 (not pending), b pending on tag 1; next cycle drive bus 0 with source 1, value 0x2A -> the following cycle issue_valid=1, issue_a=5, issue_b=0x2A.
REQ-024 Allocate with a pending on tag 0 while bus 0 asserts source 0, value 7 in the same cycle -> the entry is READY next cycle with issue_a=7.
REQ-025 Fill all 4 entries with pending operands -> alloc_ready=0, occupancy=4; with issue_ready=1, release entries one at a time -> each freed entry is reallocatable only one cycle later.
REQ-026 Allocate into entry 2, then into entry 0 after a free, both READY -> with AGE_ORDER_EN, issue_entry=2 first; without it, issue_entry=0 first.
REQ-027 Assert reset while 3 entries are WAITING and a bus match is present -> next cycle occupancy=0 and no capture occurs.
